// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile: integer register file at the consuming end of writeback.
//
// Purpose:
//   - Holds NREG architectural registers of XLEN bits. x0 is hardwired to 0.
//   - One write port (from WB) and two combinational read ports (to ID).
//     A write in progress is bypassed to same-cycle reads.
//   - Load scoreboard: one busy bit per register. It is set when ID issues a
//     load and cleared when WB retires a write to that register. While busy,
//     reads of that register raise stall_out.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   Ctl_RegWrite_in, Rd_in,
//   WriteData_in                 writeback port
//   rs1_in, rs2_in               read indices from ID
//   ReadData1_out, ReadData2_out read data (combinational, bypassed)
//   busy_set_in, busy_rd_in      load issue: mark busy_rd_in pending
//   flush_in                     drops this cycle's busy set
//   stall_out                    load-use hazard on rs1/rs2
//   busy_vec_out                 scoreboard bits (bit 0 always 0)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Ctl_RegWrite_in,
    input  logic [AW-1:0]   Rd_in,
    input  logic [XLEN-1:0] WriteData_in,
    input  logic [AW-1:0]   rs1_in,
    input  logic [AW-1:0]   rs2_in,
    output logic [XLEN-1:0] ReadData1_out,
    output logic [XLEN-1:0] ReadData2_out,
    input  logic            busy_set_in,
    input  logic [AW-1:0]   busy_rd_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic [NREG-1:0] busy_vec_out
);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // A write to x0 is not a write at all: it neither updates x0 nor clears
    // a busy bit, so fold the Rd != 0 qualifier in once here.
    logic wr_en;
    logic set_en;
    assign wr_en  = Ctl_RegWrite_in && (Rd_in != '0);
    assign set_en = busy_set_in && !flush_in && (busy_rd_in != '0);

    // Register storage. Every register needs a reset value, so this is built
    // from flops rather than RAM. Entry 0 can never match while wr_en is high,
    // so it simply holds its reset value of 0.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en && (Rd_in == AW'(gi))) begin
                    regs_reg[gi] <= WriteData_in;
                end
            end
        end
    endgenerate

    // Scoreboard next state: the clear is applied first and the set second, so
    // a new load to the same register wins over the one that is retiring.
    always_comb begin
        busy_next = busy_reg;
        if (wr_en) begin
            busy_next[Rd_in] = 1'b0;
        end
        if (set_en) begin
            busy_next[busy_rd_in] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec_out = busy_reg;

    // Read ports with write-through bypass. A bypass hit also masks the busy
    // bit, because the value the pending load was waiting for is arriving in
    // this cycle.
    logic byp1;
    logic byp2;
    logic hit1;
    logic hit2;

    assign byp1 = wr_en && (Rd_in == rs1_in);
    assign byp2 = wr_en && (Rd_in == rs2_in);

    always_comb begin
        ReadData1_out = '0;
        if (rs1_in != '0) begin
            ReadData1_out = byp1 ? WriteData_in : regs_reg[rs1_in];
        end
    end

    always_comb begin
        ReadData2_out = '0;
        if (rs2_in != '0) begin
            ReadData2_out = byp2 ? WriteData_in : regs_reg[rs2_in];
        end
    end

    assign hit1      = (rs1_in != '0) && busy_reg[rs1_in] && !byp1;
    assign hit2      = (rs2_in != '0) && busy_reg[rs2_in] && !byp2;
    assign stall_out = hit1 || hit2;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile: directed bench for wb_regfile.
//
// A behavioural model (register and busy arrays updated on each rising edge)
// predicts every output; a compare process checks all outputs against it at
// each falling edge. Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            Ctl_RegWrite_in;
    logic [AW-1:0]   Rd_in;
    logic [XLEN-1:0] WriteData_in;
    logic [AW-1:0]   rs1_in;
    logic [AW-1:0]   rs2_in;
    logic [XLEN-1:0] ReadData1_out;
    logic [XLEN-1:0] ReadData2_out;
    logic            busy_set_in;
    logic [AW-1:0]   busy_rd_in;
    logic            flush_in;
    logic            stall_out;
    logic [NREG-1:0] busy_vec_out;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .Ctl_RegWrite_in (Ctl_RegWrite_in),
        .Rd_in           (Rd_in),
        .WriteData_in    (WriteData_in),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .ReadData1_out   (ReadData1_out),
        .ReadData2_out   (ReadData2_out),
        .busy_set_in     (busy_set_in),
        .busy_rd_in      (busy_rd_in),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .busy_vec_out    (busy_vec_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_regs [NREG];
    bit          m_busy [NREG];
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 1'b0;
            end
            started = 1'b1;
        end else begin
            if (Ctl_RegWrite_in && Rd_in != 0) begin
                m_regs[Rd_in] = WriteData_in;
                m_busy[Rd_in] = 1'b0;
            end
            if (busy_set_in && !flush_in && busy_rd_in != 0)
                m_busy[busy_rd_in] = 1'b1;
        end
    end

    function automatic logic [31:0] model_read(input logic [AW-1:0] rs);
        if (rs == 0) return 32'h0;
        if (Ctl_RegWrite_in && Rd_in == rs) return WriteData_in;
        return m_regs[rs];
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] rs);
        return (rs != 0) && m_busy[rs] && !(Ctl_RegWrite_in && Rd_in == rs);
    endfunction

    logic [NREG-1:0] exp_busy;

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NREG; i++) exp_busy[i] = m_busy[i];
            check("model_rd1",   ReadData1_out, model_read(rs1_in));
            check("model_rd2",   ReadData2_out, model_read(rs2_in));
            check("model_stall", {31'b0, stall_out},
                  {31'b0, model_hit(rs1_in) || model_hit(rs2_in)});
            check("model_busy",  busy_vec_out, exp_busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rst             = 1'b0;
        Ctl_RegWrite_in = 1'b0;
        Rd_in           = '0;
        WriteData_in    = '0;
        busy_set_in     = 1'b0;
        busy_rd_in      = '0;
        flush_in        = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] rd, input logic [31:0] data);
        Ctl_RegWrite_in = 1'b1;
        Rd_in           = rd;
        WriteData_in    = data;
    endtask

    // Finish the current cycle: log the transaction, cross the rising edge.
    task automatic step();
        $display("t=%0t rst=%0b we=%0b rd=%0d wd=%h rs1=%0d rs2=%0d set=%0b brd=%0d flush=%0b",
                 $time, rst, Ctl_RegWrite_in, Rd_in, WriteData_in, rs1_in, rs2_in,
                 busy_set_in, busy_rd_in, flush_in);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst    = 1'b1;
        rs1_in = '0;
        rs2_in = '0;
        step();
        step();

        // 1. Reset clears a written register and the scoreboard
        idle();
        wr(5, 32'hDEADBEEF);
        step();
        idle();
        rs1_in = 5;
        @(negedge clk);
        check("pre_rst_x5", ReadData1_out, 32'hDEADBEEF);
        busy_set_in = 1'b1;
        busy_rd_in  = 6;
        step();
        idle();
        rst = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("rst_x5",    ReadData1_out, 32'h0);
        check("rst_busy",  busy_vec_out, 32'h0);
        check("rst_stall", {31'b0, stall_out}, 32'h0);

        // 2. x0 write discarded; x7 on both ports
        wr(0, 32'h12345678);
        rs1_in = 0;
        rs2_in = 0;
        @(negedge clk);
        check("x0_bypass", ReadData1_out, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("x0_read", ReadData2_out, 32'h0);
        wr(7, 32'hA5A5A5A5);
        step();
        idle();
        rs1_in = 7;
        rs2_in = 7;
        @(negedge clk);
        check("x7_rd1", ReadData1_out, 32'hA5A5A5A5);
        check("x7_rd2", ReadData2_out, 32'hA5A5A5A5);

        // 3. Write-through bypass
        wr(4, 32'h11);
        step();
        wr(3, 32'hCAFEF00D);
        rs1_in = 3;
        rs2_in = 4;
        @(negedge clk);
        check("byp_rd1", ReadData1_out, 32'hCAFEF00D);
        check("byp_rd2", ReadData2_out, 32'h11);
        step();
        idle();
        @(negedge clk);
        check("x3_held", ReadData1_out, 32'hCAFEF00D);

        // 4. Load-use stall released by the retiring write
        rs1_in      = 0;
        rs2_in      = 0;
        busy_set_in = 1'b1;
        busy_rd_in  = 9;
        step();
        idle();
        rs2_in = 9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lu_stall", {31'b0, stall_out}, 32'h1);
            step();
        end
        wr(9, 32'h55);
        @(negedge clk);
        check("lu_release", {31'b0, stall_out}, 32'h0);
        check("lu_bypass",  ReadData2_out, 32'h55);
        step();
        idle();
        @(negedge clk);
        check("lu_busy9", {31'b0, busy_vec_out[9]}, 32'h0);

        // 5. Simultaneous set and clear
        busy_set_in = 1'b1;
        busy_rd_in  = 9;
        step();
        wr(9, 32'h66);
        @(negedge clk);
        check("sc_same_cycle_stall", {31'b0, stall_out}, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("sc_busy9_kept", {31'b0, busy_vec_out[9]}, 32'h1);
        check("sc_stall_kept", {31'b0, stall_out}, 32'h1);
        check("sc_x9_data",    ReadData2_out, 32'h66);
        wr(9, 32'h77);
        busy_set_in = 1'b1;
        busy_rd_in  = 10;
        step();
        idle();
        rs2_in = 10;
        @(negedge clk);
        check("sc_busy_vec", busy_vec_out, 32'h0000_0400);
        check("sc_stall10",  {31'b0, stall_out}, 32'h1);
        wr(10, 32'h1010);
        step();
        idle();
        rs2_in = 0;

        // 6. Flush suppresses the set; reset clears pending loads
        busy_set_in = 1'b1;
        busy_rd_in  = 12;
        flush_in    = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("flush_busy12", {31'b0, busy_vec_out[12]}, 32'h0);
        busy_set_in = 1'b1;
        busy_rd_in  = 13;
        step();
        idle();
        rs1_in = 13;
        @(negedge clk);
        check("x13_stall", {31'b0, stall_out}, 32'h1);
        rst = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("rst2_busy",  busy_vec_out, 32'h0);
        check("rst2_stall", {31'b0, stall_out}, 32'h0);
        check("rst2_x3",    {27'b0, rs1_in} == 32'd13 ? ReadData1_out : 32'hFFFF_FFFF, 32'h0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
